// File: rtl/serial_bit_tx_pkg.sv
// serial_bit_tx_pkg: shared encodings for the serial frame transmitter
// and the matching receiver (FSM states, line levels, parameter check).
package serial_bit_tx_pkg;

   // FSM state encodings, shared with the receiver side
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // Serial line levels
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;

   // True when a parameter set describes a legal frame format
   function automatic bit params_ok(
      input int data_w,
      input int clks_per_bit,
      input int stop_bits
   );
      return (data_w >= 1) &&
             (clks_per_bit >= 1) &&
             ((stop_bits == 1) || (stop_bits == 2));
   endfunction

endpackage

// File: rtl/serial_bit_tx_bit_timer.sv
// bit_timer: bit-period counter for serial_bit_tx.
// Emits a one-cycle tick on the last cycle of every bit period.
module bit_timer
   import serial_bit_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic Clk,
   input  logic Resetn,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   // Count 0..CLKS_PER_BIT-1 and wrap; clear realigns to a new frame
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-in, serial-out frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB-first, STOP_BITS stop bits (1).
module serial_bit_tx
   import serial_bit_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic              Clk,
   input  logic              Resetn,
   input  logic [DATA_W-1:0] Data,
   input  logic              Load,
   output logic              Ready,
   output logic              Busy,
   output logic              TxD,
   output logic              Done
);

   localparam int BW = $clog2(DATA_W + 1);
   localparam int SW = $clog2(STOP_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
   localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

   generate
      if (!params_ok(DATA_W, CLKS_PER_BIT, STOP_BITS)) begin : g_bad_params
         $error("serial_bit_tx: illegal DATA_W/CLKS_PER_BIT/STOP_BITS");
      end
   endgenerate

   logic [1:0]        state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] sh_nx;
   logic [BW-1:0]     bit_idx;
   logic [SW-1:0]     stop_cnt;
   logic              accept;
   logic              tick;

   // Ready is only ever high in IDLE, so this is the IDLE-state accept
   assign accept = Load && Ready;
   assign sh_nx  = shreg >> 1;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .Clk   (Clk),
      .Resetn(Resetn),
      .clear (accept),
      .tick  (tick)
   );

   // Frame sequencer: state, shift register, counters and output registers
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state    <= S_IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         stop_cnt <= '0;
         TxD      <= LINE_IDLE;
         Ready    <= 1'b1;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         Done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  shreg    <= Data;
                  bit_idx  <= '0;
                  stop_cnt <= '0;
                  state    <= S_START;
                  TxD      <= START_LVL;
                  Ready    <= 1'b0;
                  Busy     <= 1'b1;
               end
            end
            S_START: begin
               if (tick) begin
                  state <= S_DATA;
                  TxD   <= shreg[0];
               end
            end
            S_DATA: begin
               if (tick) begin
                  shreg <= sh_nx;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     state   <= S_STOP;
                     TxD     <= LINE_IDLE;
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                     TxD     <= sh_nx[0];
                  end
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (stop_cnt == LAST_STOP) begin
                     stop_cnt <= '0;
                     state    <= S_IDLE;
                     Done     <= 1'b1;
                     Ready    <= 1'b1;
                     Busy     <= 1'b0;
                  end else begin
                     stop_cnt <= stop_cnt + SW'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               TxD   <= LINE_IDLE;
               Ready <= 1'b1;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: directed checks of serial_bit_tx framing, timing,
// reset abort, busy-ignore, back-to-back and a mid-bit receiver model.
module tb_serial_bit_tx;

   logic       clk = 1'b0;
   logic       Resetn = 1'b0;
   logic [7:0] Data = '0;
   logic       Load = 1'b0;
   logic       Ready, Busy, TxD, Done;

   logic [7:0] e_Data = '0;
   logic       e_Load = 1'b0;
   logic       e_Ready, e_Busy, e_TxD, e_Done;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   serial_bit_tx #(
      .DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)
   ) dut (
      .Clk(clk), .Resetn(Resetn), .Data(Data), .Load(Load),
      .Ready(Ready), .Busy(Busy), .TxD(TxD), .Done(Done)
   );

   serial_bit_tx #(
      .DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(2)
   ) dut_e (
      .Clk(clk), .Resetn(Resetn), .Data(e_Data), .Load(e_Load),
      .Ready(e_Ready), .Busy(e_Busy), .TxD(e_TxD), .Done(e_Done)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called at the negedge right after the accept edge (cycle j=0).
   // set_at: raise Load with set_data; drop_at: lower Load.
   task automatic frame_chk(input logic [7:0] d, input string tag,
                            input int set_at, input logic [7:0] set_data,
                            input int drop_at);
      logic [9:0] fr;
      fr = {1'b1, d, 1'b0};
      for (int j = 0; j < 40; j++) begin
         if (j == set_at) begin
            Load = 1'b1;
            Data = set_data;
         end
         if (j == drop_at) Load = 1'b0;
         chk({tag, "_txd"}, {31'd0, TxD}, {31'd0, fr[j/4]});
         chk({tag, "_done_lo"}, {31'd0, Done}, 32'd0);
         chk({tag, "_busy"}, {30'd0, Busy, Ready}, 32'd2);
         @(negedge clk);
      end
      chk({tag, "_done"}, {31'd0, Done}, 32'd1);
      chk({tag, "_ready"}, {30'd0, Busy, Ready}, 32'd1);
      chk({tag, "_line_hi"}, {31'd0, TxD}, 32'd1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cnt;
      logic [7:0] w;
      logic [7:0] rx;
      logic       ferr;
      logic [10:0] fe;

      // Reset state
      @(negedge clk);
      chk("rst_txd", {31'd0, TxD}, 32'd1);
      chk("rst_rdy", {29'd0, Ready, Busy, Done}, 32'd4);
      chk("rst_e", {28'd0, e_TxD, e_Ready, e_Busy, e_Done}, 32'hC);
      @(negedge clk);
      Resetn = 1'b1;
      @(negedge clk);

      // Single frame A5
      Data = 8'hA5;
      Load = 1'b1;
      @(negedge clk);
      frame_chk(8'hA5, "a5", -1, 8'h00, 0);
      @(negedge clk);

      // Load with 3C while busy is ignored
      Data = 8'hA5;
      Load = 1'b1;
      @(negedge clk);
      frame_chk(8'hA5, "ign", 10, 8'h3C, 11);
      cnt = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (Done || !TxD || !Ready) cnt++;
      end
      chk("ign_idle", cnt, 32'd0);

      // Back-to-back FF then 00, Load held high
      Data = 8'hFF;
      Load = 1'b1;
      @(negedge clk);
      frame_chk(8'hFF, "b2b_ff", 5, 8'h00, -1);
      @(negedge clk);
      frame_chk(8'h00, "b2b_00", -1, 8'h00, 0);
      @(negedge clk);

      // Async reset mid-DATA: line is low at j=9 (data bit 1 of A5)
      Data = 8'hA5;
      Load = 1'b1;
      @(negedge clk);
      Load = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_txd_lo", {31'd0, TxD}, 32'd0);
      Resetn = 1'b0;
      #1;
      chk("arst_txd", {31'd0, TxD}, 32'd1);
      chk("arst_rdy", {29'd0, Ready, Busy, Done}, 32'd4);
      @(negedge clk);
      Resetn = 1'b1;
      cnt = 0;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         if (Done || !TxD) cnt++;
      end
      chk("arst_no_done", cnt, 32'd0);

      // Edge parameters: CLKS_PER_BIT=1, STOP_BITS=2, data 80
      e_Data = 8'h80;
      e_Load = 1'b1;
      @(negedge clk);
      e_Load = 1'b0;
      fe = {2'b11, 8'h80, 1'b0};
      for (int j = 0; j < 11; j++) begin
         chk("edge_txd", {31'd0, e_TxD}, {31'd0, fe[j]});
         chk("edge_done_lo", {31'd0, e_Done}, 32'd0);
         @(negedge clk);
      end
      chk("edge_done", {31'd0, e_Done}, 32'd1);
      chk("edge_ready", {31'd0, e_Ready}, 32'd1);
      @(negedge clk);

      // Receiver model sampling mid-bit over 200 words
      for (int n = 0; n < 200; n++) begin
         w = 8'($urandom);
         Data = w;
         Load = 1'b1;
         @(negedge clk);
         Load = 1'b0;
         rx = '0;
         ferr = 1'b0;
         for (int j = 0; j < 40; j++) begin
            if (j % 4 == 2) begin
               if (j / 4 == 0) ferr = ferr | TxD;
               else if (j / 4 == 9) ferr = ferr | ~TxD;
               else rx[j/4 - 1] = TxD;
            end
            @(negedge clk);
         end
         chk("rx_word", {24'd0, rx}, {24'd0, w});
         chk("rx_frame", {30'd0, ferr, Done}, 32'd1);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
